// File: rtl/dpram_burst_port.sv
// dpram_burst_port
//   Burst access engine for one port of a registered-output dual-port RAM.
//   A command (start address, length, direction) is turned into per-cycle
//   RAM_ADDR / RAM_DIN / RAM_WEN. Write bursts pull bytes from a valid/ready
//   stream; read bursts issue one address per clock and re-align RAM_DOUT
//   across the fixed RD_LAT read latency.
//
//   Ports
//     CLK, RST            clock, asynchronous active-high reset
//     CMD_VLD/CMD_RDY     command handshake; CMD_WR, CMD_ADDR, CMD_LEN payload
//     WR_DATA/WR_VLD/WR_RDY  write data stream
//     RD_DATA/RD_VLD      read data, one pulse per word, no backpressure
//     DONE                1-cycle pulse at burst end
//     BUSY                high whenever not idle
//     RAM_ADDR/RAM_DIN/RAM_WEN  RAM port inputs; RAM_DOUT  RAM port output
//     CHK_XOR             (DPRAM_BURST_CRC_EN only) running XOR of burst data
//
//   Optional feature macro: DPRAM_BURST_CRC_EN
module dpram_burst_port #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VLD,
  output logic              CMD_RDY,
  input  logic              CMD_WR,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_VLD,
  output logic              WR_RDY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VLD,
  output logic              DONE,
  output logic              BUSY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DIN,
  output logic              RAM_WEN,
  input  logic [DATA_W-1:0] RAM_DOUT
`ifdef DPRAM_BURST_CRC_EN
  ,
  output logic [DATA_W-1:0] CHK_XOR
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_NULL, S_WR, S_RD, S_DRAIN} state_t;

  localparam logic [RD_LAT-1:0] TAIL_BIT = RD_LAT'(1) << (RD_LAT - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cur;
  logic [LEN_W-1:0]    rem;
  logic [RD_LAT-1:0]   pipe;
  logic                done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;

  logic cmd_acc, wr_beat, rd_issue, last_word, pipe_rest_empty;

  assign last_word       = (rem == LEN_W'(1));
  // Only the tail stage still holding a mark means the final word is on RD_VLD now.
  assign pipe_rest_empty = ((pipe & ~TAIL_BIT) == '0);

  always_comb begin
    state_n  = state;
    cmd_acc  = 1'b0;
    wr_beat  = 1'b0;
    rd_issue = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_VLD && CMD_RDY) begin
          cmd_acc = 1'b1;
          if (CMD_LEN == '0)  state_n = S_NULL;
          else if (CMD_WR)    state_n = S_WR;
          else                state_n = S_RD;
        end
      end
      S_NULL: state_n = S_IDLE;
      S_WR: begin
        if (WR_VLD) begin
          wr_beat = 1'b1;
          if (last_word) state_n = S_IDLE;
        end
      end
      S_RD: begin
        rd_issue = 1'b1;
        if (last_word) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_rest_empty) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      cur    <= '0;
      rem    <= '0;
      pipe   <= '0;
      done_q <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      state  <= state_n;
      pipe   <= (pipe << 1) | RD_LAT'(rd_issue);
      // Write bursts finish in IDLE, so their DONE is a registered pulse.
      done_q <= wr_beat && last_word;
      if (cmd_acc) begin
        cur <= CMD_ADDR;
        rem <= CMD_LEN;
      end else if (wr_beat || rd_issue) begin
        cur    <= cur + ADDR_W'(1);
        rem    <= rem - LEN_W'(1);
        addr_q <= cur;
      end
      if (wr_beat) din_q <= WR_DATA;
    end
  end

  // RAM inputs are driven combinationally on an access cycle and hold otherwise.
  assign RAM_WEN  = wr_beat;
  assign RAM_ADDR = (wr_beat || rd_issue) ? cur : addr_q;
  assign RAM_DIN  = wr_beat ? WR_DATA : din_q;

  assign CMD_RDY  = (state == S_IDLE) && !RST;
  assign WR_RDY   = (state == S_WR);
  assign BUSY     = (state != S_IDLE);
  assign RD_VLD   = pipe[RD_LAT-1];
  assign RD_DATA  = RD_VLD ? RAM_DOUT : '0;
  assign DONE     = done_q || (state == S_NULL) ||
                    ((state == S_DRAIN) && pipe_rest_empty);

`ifdef DPRAM_BURST_CRC_EN
  logic [DATA_W-1:0] chk_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chk_q <= '0;
    end else if (cmd_acc) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_q ^ (wr_beat ? WR_DATA : '0) ^ RD_DATA;
    end
  end

  // Folding in the word currently on RD_DATA makes the value complete in the
  // same cycle as a read burst's DONE.
  assign CHK_XOR = chk_q ^ RD_DATA;
`endif

endmodule

// File: tb/tb_dpram_burst_port.sv
module tb_dpram_burst_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VLD = 1'b0;
  logic        CMD_RDY;
  logic        CMD_WR = 1'b0;
  logic [14:0] CMD_ADDR = '0;
  logic [15:0] CMD_LEN = '0;
  logic [7:0]  WR_DATA = '0;
  logic        WR_VLD = 1'b0;
  logic        WR_RDY;
  logic [7:0]  RD_DATA;
  logic        RD_VLD;
  logic        DONE;
  logic        BUSY;
  logic [14:0] RAM_ADDR;
  logic [7:0]  RAM_DIN;
  logic        RAM_WEN;
  logic [7:0]  RAM_DOUT = '0;
`ifdef DPRAM_BURST_CRC_EN
  logic [7:0]  CHK_XOR;
`endif

  dpram_burst_port #(.ADDR_W(15), .DATA_W(8), .LEN_W(16), .RD_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .WR_DATA(WR_DATA), .WR_VLD(WR_VLD),
    .WR_RDY(WR_RDY), .RD_DATA(RD_DATA), .RD_VLD(RD_VLD), .DONE(DONE), .BUSY(BUSY),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_WEN(RAM_WEN), .RAM_DOUT(RAM_DOUT)
`ifdef DPRAM_BURST_CRC_EN
    , .CHK_XOR(CHK_XOR)
`endif
  );

  always #5 CLK = ~CLK;

  // Registered-output RAM: core register plus output register = 2 clocks.
  logic [7:0] mem [0:32767];
  logic [7:0] core_q = '0;
  always @(posedge CLK) begin
    if (RAM_WEN) mem[RAM_ADDR] <= RAM_DIN;
    core_q   <= mem[RAM_ADDR];
    RAM_DOUT <= core_q;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [14:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] data; } rd_t;
  typedef struct { int cyc; logic [7:0] chk; } done_t;
  wr_t   exp_wr[$];
  rd_t   exp_rd[$];
  done_t exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an event.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RAM_WEN) begin
        if (exp_wr.size() == 0) unexpected("ram_write");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("ram_write", {32'(cyc), 9'd0, RAM_ADDR, RAM_DIN}, {32'(e.cyc), 9'd0, e.addr, e.data});
        end
      end
      if (RD_VLD) begin
        if (exp_rd.size() == 0) unexpected("rd_word");
        else begin
          rd_t e;
          e = exp_rd.pop_front();
          check("rd_word", {32'(cyc), 24'd0, RD_DATA}, {32'(e.cyc), 24'd0, e.data});
        end
      end
      if (DONE) begin
        if (exp_done.size() == 0) unexpected("done");
        else begin
          done_t e;
          e = exp_done.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef DPRAM_BURST_CRC_EN
          check("chk_xor", 64'(CHK_XOR), 64'(e.chk));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents a command from a drive point; returns the accept cycle and
  // leaves the caller at the drive point of the first burst cycle.
  task automatic send_cmd(input logic wr, input logic [14:0] addr, input logic [15:0] len,
                          output int acc);
    bit ok = 1'b0;
    acc = -1000;
    CMD_VLD  = 1'b1;
    CMD_WR   = wr;
    CMD_ADDR = addr;
    CMD_LEN  = len;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (CMD_RDY) begin
        acc = cyc;
        ok  = 1'b1;
      end
      tick();
    end
    CMD_VLD = 1'b0;
    if (!ok) unexpected("cmd_accept_timeout");
  endtask

  logic [7:0] d1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] d3 [3] = '{8'hA1, 8'hB2, 8'hC3};
  logic       v3 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] d6 [3] = '{8'h0F, 8'hF0, 8'h55};

  initial begin
    int c;
    int k;
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    // Reset state
    repeat (3) tick();
    @(negedge CLK);
    check("reset_outputs", 64'({CMD_RDY, WR_RDY, RD_VLD, DONE, BUSY, RAM_WEN, RAM_ADDR, RAM_DIN, RD_DATA}), 64'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("rdy_after_reset", 64'({CMD_RDY, BUSY}), 64'b10);
    tick();

    // 1: write 4 words at 0x0010, WR_VLD steady
    send_cmd(1'b1, 15'h0010, 16'd4, c);
    for (int i = 0; i < 4; i++)
      exp_wr.push_back('{cyc: c + 1 + i, addr: 15'(32'h10 + i), data: d1[i]});
    exp_done.push_back('{cyc: c + 5, chk: 8'h44});
    for (int i = 0; i < 4; i++) begin
      WR_VLD = 1'b1;
      WR_DATA = d1[i];
      tick();
    end
    WR_VLD = 1'b0;
    repeat (3) tick();

    // 2: read them back
    send_cmd(1'b0, 15'h0010, 16'd4, c);
    for (int i = 0; i < 4; i++)
      exp_rd.push_back('{cyc: c + 3 + i, data: d1[i]});
    exp_done.push_back('{cyc: c + 6, chk: 8'h44});
    @(negedge CLK);
    check("rd_first_addr", 64'({RAM_ADDR, RAM_WEN}), 64'({15'h0010, 1'b0}));
    repeat (8) tick();

    // 3: write 3 words across the address wrap, WR_VLD toggling
    send_cmd(1'b1, 15'h7FFF, 16'd3, c);
    exp_wr.push_back('{cyc: c + 1, addr: 15'h7FFF, data: 8'hA1});
    exp_wr.push_back('{cyc: c + 3, addr: 15'h0000, data: 8'hB2});
    exp_wr.push_back('{cyc: c + 5, addr: 15'h0001, data: 8'hC3});
    exp_done.push_back('{cyc: c + 6, chk: 8'hD0});
    k = 0;
    for (int i = 0; i < 5; i++) begin
      WR_VLD = v3[i];
      if (v3[i]) begin
        WR_DATA = d3[k];
        k++;
      end else begin
        WR_DATA = 8'hEE;
      end
      tick();
    end
    WR_VLD = 1'b0;
    repeat (3) tick();

    // 4: null burst
    send_cmd(1'b1, 15'h0200, 16'd0, c);
    exp_done.push_back('{cyc: c + 1, chk: 8'h00});
    @(negedge CLK);
    check("null_ram_hold", 64'({RAM_ADDR, RAM_WEN, BUSY}), 64'({15'h0001, 1'b0, 1'b1}));
    tick();
    @(negedge CLK);
    check("null_back_idle", 64'({CMD_RDY, BUSY}), 64'b10);
    tick();

    // 6: XOR pattern write then read
    send_cmd(1'b1, 15'h0100, 16'd3, c);
    for (int i = 0; i < 3; i++)
      exp_wr.push_back('{cyc: c + 1 + i, addr: 15'(32'h100 + i), data: d6[i]});
    exp_done.push_back('{cyc: c + 4, chk: 8'hAA});
    for (int i = 0; i < 3; i++) begin
      WR_VLD = 1'b1;
      WR_DATA = d6[i];
      tick();
    end
    WR_VLD = 1'b0;
    repeat (3) tick();
    send_cmd(1'b0, 15'h0100, 16'd3, c);
    for (int i = 0; i < 3; i++)
      exp_rd.push_back('{cyc: c + 3 + i, data: d6[i]});
    exp_done.push_back('{cyc: c + 5, chk: 8'hAA});
    repeat (8) tick();

    // 5: reset during a read of 8 after 3 addresses issued
    send_cmd(1'b0, 15'h0010, 16'd8, c);
    exp_rd.push_back('{cyc: c + 3, data: 8'h11});
    repeat (3) tick();
    RST = 1'b1;
    @(negedge CLK);
    check("midburst_reset_outputs", 64'({CMD_RDY, WR_RDY, RD_VLD, DONE, BUSY, RAM_WEN, RAM_ADDR, RAM_DIN, RD_DATA}), 64'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("rdy_after_abort", 64'({CMD_RDY, BUSY}), 64'b10);
    repeat (8) tick();

    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
